// File: rtl/dma_read_controller_if.sv
// Bus master port bundle for the DMA read controller.
// The master side drives requests and begin strobes; the slave side answers with data.
interface dma_read_controller_if;
    logic        request;
    logic        granted;
    logic [31:0] address_data_in;
    logic        data_valid_in;
    logic        end_transaction_in;
    logic        busy_in;
    logic        error_in;
    logic [31:0] address_data_out;
    logic [3:0]  byte_enables_out;
    logic [7:0]  burst_size_out;
    logic        read_n_write_out;
    logic        begin_transaction_out;

    modport master (
        output request,
        input  granted,
        input  address_data_in,
        input  data_valid_in,
        input  end_transaction_in,
        input  busy_in,
        input  error_in,
        output address_data_out,
        output byte_enables_out,
        output burst_size_out,
        output read_n_write_out,
        output begin_transaction_out
    );

    modport slave (
        input  request,
        output granted,
        output address_data_in,
        output data_valid_in,
        output end_transaction_in,
        output busy_in,
        output error_in,
        input  address_data_out,
        input  byte_enables_out,
        input  burst_size_out,
        input  read_n_write_out,
        input  begin_transaction_out
    );
endinterface

// File: rtl/dma_read_controller.sv
// Bus-to-scratchpad read sequencer for the DMA custom instruction.
// Splits a block into burst reads and streams returned words into the scratchpad.
module dma_read_controller #(
    parameter int MEM_ADDR_WIDTH = 9,
    parameter int BLOCK_WIDTH    = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               bus_start_address,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_start_address,
    input  logic [BLOCK_WIDTH-1:0]    block_size,
    input  logic [7:0]                burst_size,
    output logic                      status_busy,
    output logic                      status_error,
    output logic                      transfer_done,
    dma_read_controller_if.master     bus,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata
);

    localparam int CW = ((BLOCK_WIDTH > 8) ? BLOCK_WIDTH : 8) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_BEGIN,
        S_RECEIVE,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [31:0]               bus_ptr_q, bus_ptr_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_ptr_q, mem_ptr_d;
    logic [BLOCK_WIDTH-1:0]    remaining_q, remaining_d;
    logic [7:0]                beats_max_q, beats_max_d;
    logic                      busy_q, busy_d;
    logic                      error_q, error_d;
    logic                      done_q, done_d;
    logic                      request_q, request_d;
    logic                      begin_q, begin_d;
    logic                      rnw_q, rnw_d;
    logic [31:0]               addr_out_q, addr_out_d;
    logic [3:0]                be_out_q, be_out_d;
    logic [7:0]                bs_out_q, bs_out_d;

    logic                      beat;
    logic [BLOCK_WIDTH-1:0]    rem_after;
    logic [CW-1:0]             beats_cap;
    logic [CW-1:0]             rem_ext;
    logic [CW-1:0]             burst_beats;
    logic                      unused_busy_in;

    // The slave's busy flag only matters for writes.
    assign unused_busy_in = bus.busy_in;

    // A beat is stored only while words are still owed and no error rides along.
    assign beat = (state_q == S_RECEIVE) && bus.data_valid_in &&
                  !bus.error_in && (remaining_q != '0);
    assign rem_after = beat ? remaining_q - BLOCK_WIDTH'(1) : remaining_q;

    assign beats_cap   = CW'(beats_max_q) + CW'(1);
    assign rem_ext     = CW'(remaining_q);
    assign burst_beats = (beats_cap < rem_ext) ? beats_cap : rem_ext;

    // Next-state and registered-output logic of the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        bus_ptr_d   = bus_ptr_q;
        mem_ptr_d   = mem_ptr_q;
        remaining_d = remaining_q;
        beats_max_d = beats_max_q;
        busy_d      = busy_q;
        error_d     = error_q;
        request_d   = request_q;
        done_d      = 1'b0;
        begin_d     = 1'b0;
        rnw_d       = 1'b0;
        addr_out_d  = '0;
        be_out_d    = '0;
        bs_out_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (block_size != '0) begin
                        bus_ptr_d   = bus_start_address;
                        mem_ptr_d   = mem_start_address;
                        remaining_d = block_size;
                        beats_max_d = burst_size;
                        busy_d      = 1'b1;
                        request_d   = 1'b1;
                        state_d     = S_REQUEST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_REQUEST: begin
                request_d = 1'b1;
                if (bus.granted && request_q) begin
                    begin_d    = 1'b1;
                    rnw_d      = 1'b1;
                    addr_out_d = bus_ptr_q;
                    be_out_d   = 4'hF;
                    bs_out_d   = 8'(burst_beats - CW'(1));
                    state_d    = S_BEGIN;
                end
            end
            S_BEGIN: begin
                state_d = S_RECEIVE;
            end
            S_RECEIVE: begin
                if (beat) begin
                    mem_ptr_d   = mem_ptr_q + MEM_ADDR_WIDTH'(1);
                    bus_ptr_d   = bus_ptr_q + 32'd4;
                    remaining_d = rem_after;
                end
                if (bus.error_in) begin
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    request_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else if (bus.end_transaction_in) begin
                    request_d = 1'b0;
                    if (rem_after == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQUEST;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Single state register for the FSM, its pointers and its registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            bus_ptr_q   <= '0;
            mem_ptr_q   <= '0;
            remaining_q <= '0;
            beats_max_q <= '0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            request_q   <= 1'b0;
            begin_q     <= 1'b0;
            rnw_q       <= 1'b0;
            addr_out_q  <= '0;
            be_out_q    <= '0;
            bs_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            bus_ptr_q   <= bus_ptr_d;
            mem_ptr_q   <= mem_ptr_d;
            remaining_q <= remaining_d;
            beats_max_q <= beats_max_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            done_q      <= done_d;
            request_q   <= request_d;
            begin_q     <= begin_d;
            rnw_q       <= rnw_d;
            addr_out_q  <= addr_out_d;
            be_out_q    <= be_out_d;
            bs_out_q    <= bs_out_d;
        end
    end

    assign status_busy   = busy_q;
    assign status_error  = error_q;
    assign transfer_done = done_q;

    assign bus.request               = request_q;
    assign bus.begin_transaction_out = begin_q;
    assign bus.read_n_write_out      = rnw_q;
    assign bus.address_data_out      = addr_out_q;
    assign bus.byte_enables_out      = be_out_q;
    assign bus.burst_size_out        = bs_out_q;

    assign mem_we    = beat;
    assign mem_addr  = mem_ptr_q;
    assign mem_wdata = beat ? bus.address_data_in : 32'd0;

endmodule

// File: tb/tb_dma_read_controller.sv
// Directed bench for dma_read_controller.
// A small bus slave answers bursts; a monitor logs scratchpad writes.
module tb_dma_read_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] bus_start_address;
    logic [8:0]  mem_start_address;
    logic [9:0]  block_size;
    logic [7:0]  burst_size;
    logic        status_busy;
    logic        status_error;
    logic        transfer_done;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;

    dma_read_controller_if bus ();

    dma_read_controller #(
        .MEM_ADDR_WIDTH (9),
        .BLOCK_WIDTH    (10)
    ) dut (
        .clock             (clk),
        .reset             (rst_n),
        .start             (start),
        .bus_start_address (bus_start_address),
        .mem_start_address (mem_start_address),
        .block_size        (block_size),
        .burst_size        (burst_size),
        .status_busy       (status_busy),
        .status_error      (status_error),
        .transfer_done     (transfer_done),
        .bus               (bus.master),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_begin = 0;
    int n_gap = 0;
    logic [31:0] data_ctr = 32'hD000_0000;
    logic [8:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log writes, begin strobes and request gaps seen inside a transfer.
    always @(posedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (bus.begin_transaction_out) n_begin++;
        if (status_busy && !bus.request) n_gap++;
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        n_begin = 0;
        n_gap = 0;
    endtask

    task automatic check_log(input string tag, input logic [8:0] a0,
                             input int n, input logic [31:0] d0);
        logic [8:0] ea;
        check({tag, "_nwr"}, wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            ea = a0 + 9'(i);
            check($sformatf("%s_a%0d", tag, i), 32'(wr_addr[i]), 32'(ea));
            check($sformatf("%s_d%0d", tag, i), wr_data[i], d0 + 32'(i));
        end
    endtask

    task automatic do_start(input logic [31:0] ba, input logic [8:0] ma,
                            input logic [9:0] bs, input logic [7:0] bu);
        bus_start_address = ba;
        mem_start_address = ma;
        block_size = bs;
        burst_size = bu;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_bus();
        bus.data_valid_in = 1'b0;
        bus.end_transaction_in = 1'b0;
        bus.error_in = 1'b0;
        bus.address_data_in = 32'd0;
    endtask

    // Grant one burst, check its begin cycle, then return nbeats words.
    task automatic serve(input int gdelay, input int nbeats, input int err_at,
                         input logic [31:0] exp_addr, input logic [7:0] exp_bs);
        int t;
        t = 0;
        while (!bus.request && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_seen", 32'(bus.request), 32'd1);
        repeat (gdelay) @(negedge clk);
        bus.granted = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.begin_transaction_out && t < 50);
        bus.granted = 1'b0;
        check("beg_seen", 32'(bus.begin_transaction_out), 32'd1);
        check("beg_addr", bus.address_data_out, exp_addr);
        check("beg_bs", 32'(bus.burst_size_out), 32'(exp_bs));
        check("beg_rnw_be", {27'd0, bus.read_n_write_out, bus.byte_enables_out},
              32'h1F);
        @(negedge clk);
        for (int i = 0; i < nbeats; i++) begin
            bus.data_valid_in = 1'b1;
            bus.address_data_in = data_ctr;
            data_ctr++;
            bus.error_in = (i == err_at);
            bus.end_transaction_in = (i == nbeats - 1) && (i != err_at);
            @(negedge clk);
            if (i == err_at) break;
        end
        clear_bus();
    endtask

    task automatic check_done(input string tag, input logic exp_err);
        check({tag, "_done"}, {29'd0, transfer_done, status_busy, status_error},
              {29'd0, 1'b1, 1'b0, exp_err});
        @(negedge clk);
        check({tag, "_after"}, {30'd0, transfer_done, status_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0;
        int t;
        rst_n = 1'b0;
        start = 1'b1;
        bus_start_address = 32'h100;
        mem_start_address = 9'h40;
        block_size = 10'd8;
        burst_size = 8'd7;
        bus.granted = 1'b0;
        bus.busy_in = 1'b0;
        clear_bus();

        repeat (3) @(negedge clk);
        check("rst_status", {29'd0, status_busy, status_error, transfer_done}, 0);
        check("rst_bus", {24'd0, bus.request, bus.begin_transaction_out,
              bus.read_n_write_out, bus.byte_enables_out, 1'b0}, 0);
        check("rst_addr", bus.address_data_out, 0);
        check("rst_bs", 32'(bus.burst_size_out), 0);
        check("rst_mem", {22'd0, mem_we, mem_addr}, 0);
        check("rst_wdata", mem_wdata, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_noreq", {30'd0, bus.request, status_busy}, 0);

        clear_log();
        d0 = data_ctr;
        do_start(32'h100, 9'h40, 10'd8, 8'd7);
        check("single_busy", 32'(status_busy), 1);
        serve(3, 8, -1, 32'h100, 8'd7);
        check_done("single", 1'b0);
        check_log("single", 9'h40, 8, d0);
        check("single_nbeg", n_begin, 1);
        check("single_gap", n_gap, 0);

        clear_log();
        d0 = data_ctr;
        do_start(32'h100, 9'h000, 10'h14, 8'd7);
        serve(1, 8, -1, 32'h100, 8'd7);
        serve(1, 8, -1, 32'h120, 8'd7);
        serve(1, 4, -1, 32'h140, 8'd3);
        check_done("multi", 1'b0);
        check_log("multi", 9'h000, 20, d0);
        check("multi_nbeg", n_begin, 3);
        check("multi_gap", n_gap, 2);

        clear_log();
        d0 = data_ctr;
        do_start(32'h100, 9'h1FE, 10'd4, 8'd3);
        serve(1, 2, -1, 32'h100, 8'd3);
        serve(1, 2, -1, 32'h108, 8'd1);
        check_done("wrap", 1'b0);
        check_log("wrap", 9'h1FE, 4, d0);

        clear_log();
        d0 = data_ctr;
        do_start(32'h200, 9'h010, 10'd8, 8'd7);
        serve(1, 8, 2, 32'h200, 8'd7);
        check_done("err", 1'b1);
        check_log("err", 9'h010, 2, d0);
        check("err_sticky", 32'(status_error), 1);

        clear_log();
        do_start(32'h500, 9'h0, 10'd0, 8'd7);
        check("zero_done", {29'd0, transfer_done, status_error, bus.request},
              32'h4);
        @(negedge clk);
        check("zero_after", {29'd0, transfer_done, status_busy, bus.request}, 0);
        check("zero_nbeg", n_begin, 0);

        clear_log();
        d0 = data_ctr;
        do_start(32'h300, 9'h080, 10'd2, 8'd1);
        do_start(32'h0099_9000, 9'h100, 10'd5, 8'd7);
        serve(1, 2, -1, 32'h300, 8'd1);
        check_done("busy_start", 1'b0);
        check_log("busy_start", 9'h080, 2, d0);
        repeat (3) @(negedge clk);
        check("busy_start_idle", {31'd0, bus.request}, 0);

        do_start(32'h400, 9'h020, 10'd4, 8'd3);
        bus.granted = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.begin_transaction_out && t < 50);
        bus.granted = 1'b0;
        @(negedge clk);
        bus.data_valid_in = 1'b1;
        bus.address_data_in = 32'hCAFE_0001;
        #1;
        check("mid_we", {22'd0, mem_we, mem_addr}, {22'd0, 1'b1, 9'h020});
        rst_n = 1'b0;
        #1;
        check("mid_rst", {28'd0, mem_we, bus.request, status_busy,
              bus.begin_transaction_out}, 0);
        clear_bus();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_idle", {29'd0, bus.request, status_busy, status_error}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dma_read_controller.md
Name: dma_read_controller

Overview:
- Sequencing FSM for the DMA custom instruction's bus-to-scratchpad read transfers.
- Takes a latched transfer descriptor from the CI register file: bus start address, memory start address, block size and burst size.
- Splits the block into bus burst-read transactions, arbitrates for the bus via request/granted, and streams received words into the local scratchpad write port.
- Sits between the CI register decode and the shared bus master interface; reports busy/error status back to the CI status register.

Parameters:
- MEM_ADDR_WIDTH, 9, scratchpad word-address width (512 words).
- BLOCK_WIDTH, 10, width of the block-size (word count) field.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: launch transfer with current descriptor
- bus_start_address  in  32  first bus byte address
- mem_start_address  in  MEM_ADDR_WIDTH  first scratchpad word address
- block_size  in  BLOCK_WIDTH  total words to transfer
- burst_size  in  8  max beats per burst, minus 1
- status_busy  out  1  transfer in progress
- status_error  out  1  sticky bus error of last transfer
- transfer_done  out  1  one-cycle pulse at transfer completion/abort
- request  out  1  bus request
- granted  in  1  bus grant
- address_data_in  in  32  bus read data
- data_valid_in  in  1  read beat valid
- end_transaction_in  in  1  slave ends transaction
- busy_in  in  1  slave busy (ignored for reads)
- error_in  in  1  bus error
- address_data_out  out  32  transaction address during begin, else 0
- byte_enables_out  out  4  4'hF during begin, else 0
- burst_size_out  out  8  beats-1 of current burst during begin, else 0
- read_n_write_out  out  1  1 during begin, else 0
- begin_transaction_out  out  1  begin strobe
- mem_we  out  1  scratchpad write enable
- mem_addr  out  MEM_ADDR_WIDTH  scratchpad word address
- mem_wdata  out  32  scratchpad write data

Behaviour:
- Reset (async, active-low): state IDLE. All outputs 0; internal pointers and counters 0.
- Reset asserted mid-transfer: immediate abort. No end/begin strobes issued; status_error cleared.

IDLE:
- start=1 with block_size≠0: latch bus_ptr=bus_start_address, mem_ptr=mem_start_address, remaining=block_size, beats_max=burst_size.
- Same start: clear status_error, go REQUEST.
- start=1 with block_size=0: transfer_done pulses next cycle; stay IDLE; status_error cleared.

General:
- start while status_busy=1 is ignored.
- status_busy=1 in every state except IDLE/DONE.
- request=1 in REQUEST, BEGIN and RECEIVE.

REQUEST:
- Hold request until granted=1; then go BEGIN.

BEGIN (exactly one cycle):
- begin_transaction_out=1, read_n_write_out=1, address_data_out=bus_ptr, byte_enables_out=4'hF.
- burst_size_out=min(beats_max+1, remaining)-1.
- Then go RECEIVE.

RECEIVE:
- Each cycle with data_valid_in=1: mem_we=1 combinationally the same cycle, mem_addr=mem_ptr, mem_wdata=address_data_in.
- On that same edge: mem_ptr+=1 (wraps modulo 2^MEM_ADDR_WIDTH), bus_ptr+=4 (wraps at 2^32), remaining-=1.
- error_in=1: set status_error, go DONE (remaining words discarded). error_in has priority over simultaneous data_valid_in; that beat is not written.
- end_transaction_in=1 without error: go DONE if remaining (after any same-cycle beat) is 0, else go REQUEST.
- Short bursts (end before all beats) resume from the current pointers.
- Extra beats after remaining reaches 0 are not written.

DONE:
- transfer_done=1 for one cycle, status_busy=0, then IDLE.
- status_error holds until the next accepted start.

Test Plan:
- Reset then idle: reset low with start=1 → all outputs 0; after release, no request without start.
- Single burst: bus 0x100, mem 0x40, block 8, burst 7. Grant after 3 cycles, 8 beats D0..D7 then end.
  - One begin: address 0x100, burst_size_out 7.
  - mem_we writes 0x40..0x47 in order.
  - transfer_done 1 cycle after end; status_busy=0.
- Multi-burst with truncation: block 0x14, burst 7.
  - Three begins: addresses 0x100/0x120/0x140, burst_size_out 7/7/3.
  - request drops one cycle between bursts; 20 writes total.
- Wrap and short burst: mem 0x1FE, block 4, burst 3; slave ends after 2 beats.
  - Writes 0x1FE, 0x1FF.
  - Second begin at 0x108, burst_size_out 1.
  - Writes 0x000, 0x001.
- Error: error_in on beat 3 of an 8-beat burst → 2 words written, status_error=1, transfer_done pulse. A new start clears status_error.
- Edge cases:
  - block_size=0 start → transfer_done pulse, no request.
  - start while busy → ignored.
  - reset mid-RECEIVE → request, mem_we to 0 immediately.
